// File: rtl/axis_packet_generator_if.sv
// AXI-Stream beat bundle between a packet source (master) and its sink (slave).
interface axis_packet_generator_if #(
  parameter int TDATA_WIDTH = 32
);
  logic [TDATA_WIDTH-1:0]   tdata;
  logic [TDATA_WIDTH/8-1:0] tkeep;
  logic                     tlast;
  logic                     tvalid;
  logic                     tready;

  modport master (output tdata, tkeep, tlast, tvalid, input tready);
  modport slave  (input tdata, tkeep, tlast, tvalid, output tready);
endinterface

// File: rtl/axis_packet_generator.sv
// AXI-Stream packet source: on start, emits one packet of programmed length and
// data pattern, holds each beat under backpressure, then pulses done.
module axis_packet_generator #(
  parameter int TDATA_WIDTH    = 32,
  parameter int MAX_PACKET_LEN = 16
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic                     start,
  input  logic [1:0]               pattern,
  input  logic [TDATA_WIDTH-1:0]   seed,
  input  logic [7:0]               pkt_len,
  input  logic [TDATA_WIDTH/8-1:0] last_keep,
  input  logic [3:0]               gap_cycles,
  axis_packet_generator_if.master  m_axis,
  output logic                     busy,
  output logic                     done,
  output logic [15:0]              pkt_count
);

  localparam int                KEEP_W     = TDATA_WIDTH / 8;
  localparam logic [7:0]        MAX_LEN_C  = 8'(MAX_PACKET_LEN);
  localparam logic [KEEP_W-1:0] KEEP_ALL_C = {KEEP_W{1'b1}};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SEND = 2'd1,
    ST_GAP  = 2'd2
  } state_t;

  state_t                   state_r;
  logic [1:0]               pattern_r;
  logic [TDATA_WIDTH-1:0]   seed_r;
  logic [7:0]               len_r;
  logic [7:0]               k_r;
  logic [KEEP_W-1:0]        keep_last_r;
  logic [3:0]               gap_r;
  logic [3:0]               gap_cnt_r;
  logic [TDATA_WIDTH-1:0]   tdata_r;
  logic [KEEP_W-1:0]        tkeep_r;
  logic                     tlast_r;
  logic                     tvalid_r;
  logic                     busy_r;
  logic                     done_r;
  logic [15:0]              pkt_count_r;

  logic [7:0]               len_clamp_s;
  logic [KEEP_W-1:0]        keep_eff_s;
  logic [7:0]               k_next_s;
  logic                     next_is_last_s;
  logic                     handshake_s;

  // Data of beat k for the given pattern; patterns 0 and 3 both increment.
  function automatic logic [TDATA_WIDTH-1:0] beat_data(
    input logic [1:0]             pat,
    input logic [TDATA_WIDTH-1:0] sd,
    input logic [7:0]             k
  );
    logic [TDATA_WIDTH-1:0] d;
    case (pat)
      2'd1:    d = sd;
      2'd2:    d = k[0] ? ~sd : sd;
      default: d = sd + TDATA_WIDTH'(k);
    endcase
    return d;
  endfunction

  // Byte enables of a beat: only the final beat carries the programmed keep.
  function automatic logic [KEEP_W-1:0] beat_keep(
    input logic              is_last,
    input logic [KEEP_W-1:0] lk
  );
    return is_last ? lk : KEEP_ALL_C;
  endfunction

  assign len_clamp_s    = (pkt_len > MAX_LEN_C) ? MAX_LEN_C : pkt_len;
  assign keep_eff_s     = (last_keep == {KEEP_W{1'b0}}) ? KEEP_ALL_C : last_keep;
  assign k_next_s       = k_r + 8'd1;
  assign next_is_last_s = (k_next_s == (len_r - 8'd1));
  assign handshake_s    = tvalid_r && m_axis.tready;

  // Packet FSM with all stream and status outputs registered.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state_r     <= ST_IDLE;
      pattern_r   <= 2'd0;
      seed_r      <= {TDATA_WIDTH{1'b0}};
      len_r       <= 8'd0;
      k_r         <= 8'd0;
      keep_last_r <= {KEEP_W{1'b0}};
      gap_r       <= 4'd0;
      gap_cnt_r   <= 4'd0;
      tdata_r     <= {TDATA_WIDTH{1'b0}};
      tkeep_r     <= {KEEP_W{1'b0}};
      tlast_r     <= 1'b0;
      tvalid_r    <= 1'b0;
      busy_r      <= 1'b0;
      done_r      <= 1'b0;
      pkt_count_r <= 16'd0;
    end else begin
      done_r <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (start && (pkt_len != 8'd0)) begin
            pattern_r   <= pattern;
            seed_r      <= seed;
            len_r       <= len_clamp_s;
            keep_last_r <= keep_eff_s;
            gap_r       <= gap_cycles;
            k_r         <= 8'd0;
            tdata_r     <= beat_data(pattern, seed, 8'd0);
            tkeep_r     <= beat_keep(len_clamp_s == 8'd1, keep_eff_s);
            tlast_r     <= (len_clamp_s == 8'd1);
            tvalid_r    <= 1'b1;
            busy_r      <= 1'b1;
            state_r     <= ST_SEND;
          end
        end
        ST_SEND: begin
          if (handshake_s) begin
            if (tlast_r) begin
              tvalid_r    <= 1'b0;
              tlast_r     <= 1'b0;
              done_r      <= 1'b1;
              pkt_count_r <= pkt_count_r + 16'd1;
              if (gap_r != 4'd0) begin
                gap_cnt_r <= gap_r;
                state_r   <= ST_GAP;
              end else begin
                busy_r  <= 1'b0;
                state_r <= ST_IDLE;
              end
            end else begin
              k_r     <= k_next_s;
              tdata_r <= beat_data(pattern_r, seed_r, k_next_s);
              tkeep_r <= beat_keep(next_is_last_s, keep_last_r);
              tlast_r <= next_is_last_s;
            end
          end
        end
        ST_GAP: begin
          // busy falls on the edge that completes the last idle cycle
          if (gap_cnt_r == 4'd1) begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end else begin
            gap_cnt_r <= gap_cnt_r - 4'd1;
          end
        end
        default: begin
          tvalid_r <= 1'b0;
          tlast_r  <= 1'b0;
          busy_r   <= 1'b0;
          state_r  <= ST_IDLE;
        end
      endcase
    end
  end

  assign m_axis.tdata  = tdata_r;
  assign m_axis.tkeep  = tkeep_r;
  assign m_axis.tlast  = tlast_r;
  assign m_axis.tvalid = tvalid_r;
  assign busy          = busy_r;
  assign done          = done_r;
  assign pkt_count     = pkt_count_r;

endmodule

// File: doc/axis_packet_generator.md
# axis_packet_generator

AXI-Stream packet source: the transmit end that drives the slave port of the stream processor. On a `start` pulse it emits one packet of a programmed beat count and data pattern on its master port. It keeps every beat stable under backpressure, then reports completion. It is used as the stimulus source in the stream-processing subsystem and as a built-in traffic generator for bring-up.

## Interface
- `TDATA_WIDTH`, 32, data width in bits; multiple of 8.
- `MAX_PACKET_LEN`, 16, maximum beats per packet (1..255).

- `aclk`  in  1  clock; all logic on rising edge.
- `aresetn`  in  1  asynchronous, active-low reset.
- `start`  in  1  request one packet; sampled only in IDLE.
- `pattern`  in  2  data pattern: 0 increment, 1 constant, 2 alternate, 3 = increment.
- `seed`  in  TDATA_WIDTH  first beat data.
- `pkt_len`  in  8  beats per packet; 0 = request ignored; >MAX_PACKET_LEN clamped to MAX_PACKET_LEN.
- `last_keep`  in  TDATA_WIDTH/8  tkeep on final beat; 0 treated as all-ones.
- `gap_cycles`  in  4  idle cycles inserted after each packet before returning to IDLE.
- `m_axis_tdata`  out  TDATA_WIDTH  beat data.
- `m_axis_tkeep`  out  TDATA_WIDTH/8  byte enables.
- `m_axis_tlast`  out  1  final beat marker.
- `m_axis_tvalid`  out  1  beat valid.
- `m_axis_tready`  in  1  downstream ready.
- `busy`  out  1  high in SEND and GAP.
- `done`  out  1  one-cycle pulse after final beat accepted.
- `pkt_count`  out  16  completed packets, wraps 0xFFFF→0.

## Operation
- FSM states:
  - IDLE: `start` with `pkt_len`≠0 latches `pattern`, `seed`, clamped length and `last_keep`, then goes to SEND. `start` with `pkt_len`=0 stays in IDLE and has no effect.
  - SEND: drives beat k (k = 0..L-1). Advances k on `m_axis_tvalid && m_axis_tready`. After handshake of beat L-1 goes to GAP if the latched `gap_cycles`≠0, else to IDLE.
  - GAP: counts down the `gap_cycles` value latched at start, then goes to IDLE.
- `start` in SEND or GAP is ignored and is not queued.
- Config inputs changing after acceptance have no effect on the packet in flight.
- Beat data, modulo 2^TDATA_WIDTH:
  - pattern 0 and 3: `seed` + k.
  - pattern 1: `seed`.
  - pattern 2: `seed` when k is even, `~seed` when k is odd.
- `m_axis_tkeep` is all-ones except on beat L-1, which carries the latched `last_keep` (all-ones if it was 0).
- `m_axis_tlast` is high only on beat L-1. For L=1 the single beat carries tlast and last_keep.
- AXI rule: once tvalid is high, tdata, tkeep and tlast are held constant and tvalid stays high until handshake. tvalid never depends combinationally on tready.

## Timing
- Reset (async assert, sync deassert by design): tvalid, tlast, done, busy = 0; tdata = 0; tkeep = 0; pkt_count = 0; FSM to IDLE.
- Reset mid-packet aborts the packet immediately. No tlast is emitted and pkt_count is not incremented.
- Latency: `start` sampled at edge N → tvalid and busy are high from edge N onward (start-to-first-beat is 1 cycle).
- With continuous tready, beats go back-to-back, one per cycle. An L-beat packet occupies edges N+1..N+L.
- The final-beat handshake at edge M causes all of the following:
  - tvalid drops after M.
  - done is high for the cycle after M.
  - pkt_count increments at M.
  - busy drops after M if gap_cycles=0, else after edge M+gap_cycles.
- Earliest next start: sampled at the first edge where the FSM is in IDLE. With gap_cycles=0, start asserted in the done cycle is accepted, giving a 1-cycle bubble between packets.
- tready low for any number of cycles stalls k with outputs frozen. There is no timeout.

## Test plan
- Increment: seed=0x12345678, pkt_len=3, pattern=0, tready=1 → beats 0x12345678, 0x12345679, 0x1234567A; tlast only on third; done one cycle later; pkt_count=1.
- Wrap and alternate:
  - pattern 0, seed=0xFFFFFFFF, pkt_len=2 → 0xFFFFFFFF then 0x00000000.
  - pattern 2, seed=0xAABBCCDD, pkt_len=3 → 0xAABBCCDD, 0x55443322, 0xAABBCCDD.
- Backpressure: pkt_len=4, tready low 3 cycles during beat 1 → beat 1's tdata, tkeep and tlast stay constant with tvalid high; exactly 4 handshakes, in order.
- Single beat with partial keep: pkt_len=1, last_keep=4'b1100 → one beat, tkeep=1100, tlast=1. Repeat with last_keep=0 → tkeep=1111.
- Length edges and gap:
  - pkt_len=0 → no tvalid, no done.
  - pkt_len=200 → 16 beats.
  - gap_cycles=5 → busy stays high 5 cycles after done; start during GAP is ignored.
- Reset mid-packet: aresetn low during beat 2 of 5 → all outputs 0 immediately, pkt_count=0. A new start after release sends a full packet from beat 0.
